mmu_dport: RTL
==============

# mmu_dport

Parametrised data-side memory port for the pipelined RV32I core. Accepts one load/store per cycle through a req/ready handshake. Decodes the address against bounded ROM, RAM and I/O windows, steers byte lanes from addr[1:0] and the access size, and performs load sign/zero extension. Adds what the previous MMU lacked: a variable-latency I/O handshake with wait states, misalignment and unmapped-address fault reporting, and ROM write protection.

## Interface
Parameters:
- ROM_WORDS_LOG, 9: ROM depth in 32-bit words (log2); window 0x0 .. 4·2^ROM_WORDS_LOG−1.
- RAM_BASE, 32'h10000000: RAM window base; must be word aligned.
- RAM_WORDS_LOG, 14: RAM depth in words (log2); window RAM_BASE .. RAM_BASE+4·2^RAM_WORDS_LOG−1.
- IO_BASE, 32'h80000000: I/O window base.
- IO_ADDR_W, 8: I/O window size is 2^IO_ADDR_W bytes.
- IO_TIMEOUT, 15: I/O wait limit in cycles; only used with the timeout macro.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req, we, is_signed  in  1 each  access request, store, signed load.
- size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- addr, wdata  in  32 each  byte address; store data, right-aligned.
- ready  out  1  a request is accepted on cycles where req && ready.
- done  out  1  one-cycle completion pulse for every accepted request.
- rdata  out  32  extended load data; 0 for stores, faults and when done=0.
- fault  out  1  qualifies done.
- fault_cause  out  2  0 misaligned/illegal size, 1 unmapped, 2 ROM write, 3 I/O timeout.
- rom_addr  out  ROM_WORDS_LOG  ROM port-B word address; rom_rdata  in  32, 1-cycle latency.
- ram_addr  out  RAM_WORDS_LOG  word address.
- ram_we  out  1  write enable.
- ram_wmask  out  4  byte write mask.
- ram_wdata  out  32  lane-steered store data.
- ram_rdata  in  32  1-cycle latency.
- io_en, io_we  out  1 each  registered I/O strobe and write flag.
- io_addr  out  IO_ADDR_W  byte offset from IO_BASE.
- io_be  out  4  lane enables.
- io_wdata  out  32  lane-steered store data.
- io_rdata  in  32  read data; io_ack  in  1  completes the I/O access.

## Operation
- Accept check: misaligned (half with addr[0]=1, word with addr[1:0]≠0, size=11) > unmapped > ROM store; first match is the fault cause.
- Lane mask: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111. Store data is replicated into lanes; the mask selects.
- FSM states: IDLE, MEM, ERR, IO, RESP.
- IDLE or any done state (MEM/ERR/RESP) with req accepted: fault → ERR; ROM/RAM → MEM; I/O → IO.
- Done state without req → IDLE.
- ROM/RAM: addresses and ram_we/ram_wmask are driven combinationally in the accept cycle. ram_we is asserted only for accepted, fault-free RAM stores.
- MEM: done=1; rdata is extracted from rom_rdata/ram_rdata using the registered mask, offset and is_signed.
- IO: io_en=1 with registered io_addr, io_we, io_be and io_wdata, held stable until io_ack. On io_ack: io_rdata is captured, io_en drops, next state RESP.
- RESP: done=1 with the captured data extracted.
- ERR: done=1, fault=1, fault_cause valid. No memory or I/O side effect.
- ready = state ≠ IO.

## Timing
- Reset: state IDLE. done, fault, fault_cause, rdata, io_en, io_we, io_addr, io_be and io_wdata all 0. ram_we=0.
- ROM/RAM/fault latency: done in cycle N+1 for accept in cycle N. Full throughput back-to-back.
- I/O: io_en high from N+1. io_ack sampled in cycle M gives done in M+1. io_ack while io_en=0 is ignored. Minimum I/O latency is 2 cycles.
- Reset mid-I/O: io_en is 0 the next cycle; no done is issued for the aborted access.

## Configuration
- MMU_IO_TIMEOUT_EN defined: a counter runs while in IO. After IO_TIMEOUT cycles with io_en=1 and no io_ack, io_en drops and the block goes to ERR (fault_cause 3). io_ack in the final cycle still wins.
- Undefined: I/O waits indefinitely; cause 3 is never produced.

## Test plan
- sw 0x10000004 ← 0xDEADBEEF, then lb signed at 0x10000007 → done at N+1, rdata 0xFFFFFFDE; lbu → 0x000000DE.
- lhu at 0x10000006 and lw at 0x10000004 issued on consecutive cycles → done on two consecutive cycles, rdata 0x0000DEAD then 0xDEADBEEF.
- Faults, with ram_we never asserted:
  - lw 0x10000002 → fault cause 0.
  - sw 0x00000010 → cause 2.
  - lw 0x10010000 (RAM_WORDS_LOG=14) → cause 1.
- sb 0x80000013 data 0xA5 → io_en at N+1, io_addr 0x13, io_be 1000, io_wdata 0xA5A5A5A5. io_ack 3 cycles later → done the cycle after, ready low throughout IO.
- With MMU_IO_TIMEOUT_EN, IO_TIMEOUT=4, no io_ack → io_en high exactly 4 cycles, then done, fault, cause 3.
- reset asserted during an I/O wait → io_en 0 next cycle, no done; next lw 0x00000000 returns the ROM word at N+1.

Source files
------------

// File: rtl/mmu_dport_if.sv
// Core-side load/store bus of the data memory port.
// The core drives the request side; the port answers with ready/done/rdata/fault.
interface mmu_dport_if;
    logic        req;
    logic        we;
    logic        is_signed;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic [31:0] rdata;
    logic        fault;
    logic [1:0]  fault_cause;

    modport master (
        output req, we, is_signed, size, addr, wdata,
        input  ready, done, rdata, fault, fault_cause
    );

    modport slave (
        input  req, we, is_signed, size, addr, wdata,
        output ready, done, rdata, fault, fault_cause
    );
endinterface

// File: rtl/mmu_dport.sv
// Data-side memory port: ROM/RAM/I/O window decode, byte-lane steering, load extension, fault reporting.
// Optional I/O wait timeout is enabled by defining MMU_IO_TIMEOUT_EN.
module mmu_dport #(
    parameter int          ROM_WORDS_LOG = 9,
    parameter logic [31:0] RAM_BASE      = 32'h1000_0000,
    parameter int          RAM_WORDS_LOG = 14,
    parameter logic [31:0] IO_BASE       = 32'h8000_0000,
    parameter int          IO_ADDR_W     = 8,
    parameter int          IO_TIMEOUT    = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    mmu_dport_if.slave               bus,
    output logic [ROM_WORDS_LOG-1:0] rom_addr,
    input  logic [31:0]              rom_rdata,
    output logic [RAM_WORDS_LOG-1:0] ram_addr,
    output logic                     ram_we,
    output logic [3:0]               ram_wmask,
    output logic [31:0]              ram_wdata,
    input  logic [31:0]              ram_rdata,
    output logic                     io_en,
    output logic                     io_we,
    output logic [IO_ADDR_W-1:0]     io_addr,
    output logic [3:0]               io_be,
    output logic [31:0]              io_wdata,
    input  logic [31:0]              io_rdata,
    input  logic                     io_ack
);

    localparam int TMO_W = $clog2(IO_TIMEOUT + 1);
`ifdef MMU_IO_TIMEOUT_EN
    localparam logic TMO_EN = 1'b1;
`else
    localparam logic TMO_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MEM  = 3'd1,
        S_ERR  = 3'd2,
        S_IO   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t             state_r, state_nxt_s;
    logic               ready_s, acc_s;
    logic               misalign_s, fault_s;
    logic [1:0]         cause_s;
    logic [3:0]         mask_s;
    logic [31:0]        wdata_steer_s;
    logic               in_rom_s, in_ram_s, in_io_s;
    logic [29:0]        ram_off_s;
    logic [31:0]        io_off_s;
    logic               tmo_s;

    logic               we_r, signed_r, src_ram_r;
    logic [1:0]         size_r, off_r, cause_r;
    logic [31:0]        io_data_r;
    logic [TMO_W-1:0]   tmo_cnt_r;
    logic               io_en_r, io_we_r;
    logic [IO_ADDR_W-1:0] io_addr_r;
    logic [3:0]         io_be_r;
    logic [31:0]        io_wdata_r;

    function automatic logic [31:0] steer_wdata(input logic [31:0] d, input logic [1:0] sz);
        case (sz)
            2'b00:   steer_wdata = {4{d[7:0]}};
            2'b01:   steer_wdata = {2{d[15:0]}};
            default: steer_wdata = d;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] off,
                                                 input logic [1:0] sz, input logic sgn);
        logic [31:0] sh;
        sh = w >> {off, 3'b000};
        case (sz)
            2'b00:   load_extract = {{24{sgn & sh[7]}}, sh[7:0]};
            2'b01:   load_extract = {{16{sgn & sh[15]}}, sh[15:0]};
            default: load_extract = sh;
        endcase
    endfunction

    assign ready_s   = (state_r != S_IO);
    assign acc_s     = bus.req && ready_s;
    assign bus.ready = ready_s;

    assign in_rom_s  = (bus.addr[31:ROM_WORDS_LOG+2] == '0);
    assign ram_off_s = bus.addr[31:2] - RAM_BASE[31:2];
    assign in_ram_s  = (ram_off_s[29:RAM_WORDS_LOG] == '0);
    assign io_off_s  = bus.addr - IO_BASE;
    assign in_io_s   = (io_off_s[31:IO_ADDR_W] == '0);

    assign wdata_steer_s = steer_wdata(bus.wdata, bus.size);

    // Lane mask and alignment check from size and low address bits
    always_comb begin
        misalign_s = 1'b0;
        mask_s     = 4'b0000;
        case (bus.size)
            2'b00: mask_s = 4'b0001 << bus.addr[1:0];
            2'b01: begin
                mask_s     = 4'b0011 << bus.addr[1:0];
                misalign_s = bus.addr[0];
            end
            2'b10: begin
                mask_s     = 4'b1111;
                misalign_s = (bus.addr[1:0] != 2'b00);
            end
            default: misalign_s = 1'b1;
        endcase
    end

    // Prioritised fault classification of the presented request
    always_comb begin
        fault_s = 1'b1;
        cause_s = 2'd0;
        if (misalign_s) begin
            cause_s = 2'd0;
        end else if (!(in_rom_s || in_ram_s || in_io_s)) begin
            cause_s = 2'd1;
        end else if (in_rom_s && bus.we) begin
            cause_s = 2'd2;
        end else begin
            fault_s = 1'b0;
        end
    end

    // Memory ports are driven straight from the request so data returns next cycle
    assign rom_addr  = bus.addr[ROM_WORDS_LOG+1:2];
    assign ram_addr  = ram_off_s[RAM_WORDS_LOG-1:0];
    assign ram_we    = acc_s && !fault_s && in_ram_s && !in_rom_s && bus.we;
    assign ram_wmask = mask_s;
    assign ram_wdata = wdata_steer_s;

    assign tmo_s = TMO_EN && (tmo_cnt_r == TMO_W'(IO_TIMEOUT - 1));

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IO: begin
                if (io_ack) begin
                    state_nxt_s = S_RESP;
                end else if (tmo_s) begin
                    state_nxt_s = S_ERR;
                end else begin
                    state_nxt_s = S_IO;
                end
            end
            S_IDLE, S_MEM, S_ERR, S_RESP: begin
                if (!acc_s) begin
                    state_nxt_s = S_IDLE;
                end else if (fault_s) begin
                    state_nxt_s = S_ERR;
                end else if (in_rom_s || in_ram_s) begin
                    state_nxt_s = S_MEM;
                end else begin
                    state_nxt_s = S_IO;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_r <= S_IDLE;
        else       state_r <= state_nxt_s;
    end

    // Request capture, I/O strobe registers and wait counter
    always_ff @(posedge clk) begin
        if (reset) begin
            we_r       <= 1'b0;
            signed_r   <= 1'b0;
            src_ram_r  <= 1'b0;
            size_r     <= 2'b00;
            off_r      <= 2'b00;
            cause_r    <= 2'd0;
            io_data_r  <= 32'h0000_0000;
            tmo_cnt_r  <= '0;
            io_en_r    <= 1'b0;
            io_we_r    <= 1'b0;
            io_addr_r  <= '0;
            io_be_r    <= 4'b0000;
            io_wdata_r <= 32'h0000_0000;
        end else begin
            io_en_r <= (state_nxt_s == S_IO);
            if (acc_s) begin
                we_r      <= bus.we;
                signed_r  <= bus.is_signed;
                src_ram_r <= !in_rom_s;
                size_r    <= bus.size;
                off_r     <= bus.addr[1:0];
                cause_r   <= cause_s;
            end
            if (acc_s && !fault_s && !in_rom_s && !in_ram_s) begin
                io_we_r    <= bus.we;
                io_addr_r  <= io_off_s[IO_ADDR_W-1:0];
                io_be_r    <= mask_s;
                io_wdata_r <= wdata_steer_s;
            end
            if (state_r == S_IO && io_ack) begin
                io_data_r <= io_rdata;
            end
            if (state_r == S_IO && !io_ack && tmo_s) begin
                cause_r <= 2'd3;
            end
            if (state_r == S_IO && !io_ack && !tmo_s) begin
                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end else begin
                tmo_cnt_r <= '0;
            end
        end
    end

    assign io_en    = io_en_r;
    assign io_we    = io_we_r;
    assign io_addr  = io_addr_r;
    assign io_be    = io_be_r;
    assign io_wdata = io_wdata_r;

    // Completion outputs decoded from the done states
    always_comb begin
        bus.done        = 1'b0;
        bus.fault       = 1'b0;
        bus.fault_cause = 2'd0;
        bus.rdata       = 32'h0000_0000;
        case (state_r)
            S_MEM: begin
                bus.done = 1'b1;
                if (!we_r) begin
                    bus.rdata = load_extract(src_ram_r ? ram_rdata : rom_rdata, off_r, size_r, signed_r);
                end else begin
                    bus.rdata = 32'h0000_0000;
                end
            end
            S_RESP: begin
                bus.done = 1'b1;
                if (!we_r) begin
                    bus.rdata = load_extract(io_data_r, off_r, size_r, signed_r);
                end else begin
                    bus.rdata = 32'h0000_0000;
                end
            end
            S_ERR: begin
                bus.done        = 1'b1;
                bus.fault       = 1'b1;
                bus.fault_cause = cause_r;
            end
            default: bus.done = 1'b0;
        endcase
    end

endmodule
